// File: rtl/croc_pkg.sv
// OBI manager request/response types shared by user-domain managers.
package croc_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain constants: manager indices and the DMA reader FSM encoding.
package user_pkg;

  localparam int unsigned NumUserDomainManagers = 1;
  localparam int unsigned UserDmaReader         = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } user_dma_reader_state_e;

endpackage

// File: rtl/user_dma_fifo.sv
// Small circular response buffer; head reads as zero while empty.
module user_dma_fifo #(
  parameter  int unsigned DEPTH  = 2,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only, so it stays out of the reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/user_dma_reader.sv
// Streams len_i consecutive words from OBI memory; credit-limited issue.
// Optional USER_DMA_READER_CHECKSUM_EN adds an XOR checksum of streamed words.
module user_dma_reader
  import user_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned LenWidth       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [31:0]           src_addr_i,
  input  logic [LenWidth-1:0]   len_i,
  output croc_pkg::mgr_obi_req_t obi_req_o,
  input  croc_pkg::mgr_obi_rsp_t obi_rsp_i,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef USER_DMA_READER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum_o
`endif
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  user_dma_reader_state_e state, next_state;

  logic [31:0]         addr;
  logic [LenWidth-1:0] issue_left;
  logic [CntW-1:0]     outstanding;
  logic [CntW-1:0]     fifo_count;
  logic [CntW:0]       inflight;
  logic                fifo_empty;
  logic                accept_start, can_issue, req, fire, rsp_accept, pop;
  logic                unused_bits;

  assign unused_bits  = ^{src_addr_i[1:0], obi_rsp_i.r.rid};

  assign accept_start = (state == IDLE) && start_i;
  // Responses already in flight plus buffered words must never exceed the
  // buffer depth, so an rvalid always finds room.
  assign inflight     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign can_issue    = (issue_left != '0) && (inflight < (CntW + 1)'(MaxOutstanding));
  assign fire         = req && obi_rsp_i.gnt;
  // Zero outstanding means the response belongs to an abandoned transfer.
  assign rsp_accept   = obi_rsp_i.rvalid && (outstanding != '0);
  assign valid_o      = !fifo_empty;
  assign pop          = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_i) next_state = (len_i == '0) ? DONE : ISSUE;
      ISSUE: if (fire && issue_left == LenWidth'(1)) next_state = DRAIN;
      DRAIN: if (outstanding == '0 && fifo_empty) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req               = (state == ISSUE) && can_issue;
    busy_o            = (state == ISSUE) || (state == DRAIN);
    done_o            = (state == DONE);
    obi_req_o         = '0;
    obi_req_o.req     = req;
    obi_req_o.a.addr  = addr;
    obi_req_o.a.be    = 4'hF;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr        <= '0;
      issue_left  <= '0;
      outstanding <= '0;
      err_o       <= 1'b0;
    end else begin
      if (accept_start) begin
        addr       <= {src_addr_i[31:2], 2'b00};
        issue_left <= len_i;
      end else if (fire) begin
        addr       <= addr + 32'd4;
        issue_left <= issue_left - 1'b1;
      end
      case ({fire, rsp_accept})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (accept_start)                       err_o <= 1'b0;
      else if (rsp_accept && obi_rsp_i.r.err) err_o <= 1'b1;
    end
  end

  user_dma_fifo #(
    .DEPTH  (MaxOutstanding),
    .DATA_W (32)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (rsp_accept),
    .wdata (obi_rsp_i.r.rdata),
    .pop   (pop),
    .rdata (data_o),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef USER_DMA_READER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           checksum_o <= '0;
    else if (accept_start) checksum_o <= '0;
    else if (pop)          checksum_o <= checksum_o ^ data_o;
  end
`endif

endmodule

// File: tb/tb_user_dma_reader.sv
// Bench for user_dma_reader: random OBI slave timing against a queue-based transfer model.
module tb_user_dma_reader;
  import croc_pkg::*;

  localparam int MAXO = 2;
  localparam int LW   = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [31:0]   src_addr_i;
  logic [LW-1:0] len_i;
  mgr_obi_req_t  obi_req;
  mgr_obi_rsp_t  obi_rsp;
  logic [31:0]   data;
  logic          valid, ready, busy, done, err;
`ifdef USER_DMA_READER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  always #5 clk = ~clk;

  user_dma_reader #(
    .MaxOutstanding (MAXO),
    .LenWidth       (LW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .len_i      (len_i),
    .obi_req_o  (obi_req),
    .obi_rsp_i  (obi_rsp),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
`ifdef USER_DMA_READER_CHECKSUM_EN
    ,
    .checksum_o (checksum)
`endif
  );

  int checks, failures;
  int cyc, done_cyc;
  bit in_xfer;
  int issue_left, total, popped;
  logic [31:0] exp_addr;
  logic [31:0] pq[$];      // granted, not yet answered
  logic [31:0] sq[$];      // answered, not yet taken from the stream
  logic [31:0] forced[$];  // response data to use before random data
  bit err_m;
  logic [31:0] cs_m;
  int gnt_pct, rv_pct, rdy_pct, hold_rdy, err_idx, resp_idx;
  bit stray_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, obi_req.req, 0);
    chk({tag, "_addr"}, obi_req.a.addr, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
`ifdef USER_DMA_READER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  task automatic clear_model();
    pq.delete(); sq.delete(); forced.delete();
    in_xfer = 0; issue_left = 0; total = 0; popped = 0;
    err_m = 0; cs_m = 0; done_cyc = -1; exp_addr = 0;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit do_start, input logic [31:0] s_src, input int s_len);
    bit g, rv, rdy, e, exp_done, exp_req, idle_m;
    logic [31:0] d;
    @(negedge clk);
    cyc++;
    exp_done = (cyc == done_cyc);
    exp_req  = in_xfer && (issue_left > 0) && (pq.size() + sq.size() < MAXO);
    chk("done", done, exp_done);
    chk("busy", busy, in_xfer && !exp_done);
    chk("req", obi_req.req, exp_req);
    if (obi_req.req) begin
      chk("addr", obi_req.a.addr, exp_addr);
      chk("we_be", {obi_req.a.we, obi_req.a.be}, 5'h0F);
      chk("wdata_aid", obi_req.a.wdata | 32'(obi_req.a.aid), 0);
    end
    chk("valid", valid, sq.size() > 0);
    if (sq.size() > 0) chk("data", data, sq[0]);
    chk("err", err, err_m);
`ifdef USER_DMA_READER_CHECKSUM_EN
    chk("checksum", checksum, cs_m);
`endif

    g = ($urandom_range(99) < gnt_pct);
    if (hold_rdy > 0) begin
      rdy = 0;
      hold_rdy--;
    end else begin
      rdy = ($urandom_range(99) < rdy_pct);
    end
    rv = (pq.size() > 0) && ($urandom_range(99) < rv_pct);
    d  = $urandom;
    e  = 0;
    if (rv) begin
      void'(pq.pop_front());
      if (forced.size() > 0) d = forced.pop_front();
      e = (resp_idx == err_idx);
      resp_idx++;
    end
    obi_rsp.gnt     = g;
    obi_rsp.rvalid  = rv || stray_rv;
    obi_rsp.r.rdata = d;
    obi_rsp.r.err   = rv ? e : (stray_rv ? 1'b1 : 1'($urandom_range(1)));
    obi_rsp.r.rid   = '0;
    stray_rv        = 0;
    ready      = rdy;
    start_i    = do_start;
    src_addr_i = s_src;
    len_i      = LW'(s_len);

    idle_m = !in_xfer && !exp_done;
    if (exp_req && g) begin
      pq.push_back(exp_addr);
      exp_addr += 32'd4;
      issue_left--;
    end
    if (valid && rdy && sq.size() > 0) begin
      cs_m ^= sq.pop_front();
      popped++;
      if (popped == total) done_cyc = cyc + 2;
    end
    if (rv) begin
      sq.push_back(d);
      if (e) err_m = 1;
    end
    if (do_start && idle_m) begin
      err_m = 0; cs_m = 0;
      total = s_len; popped = 0; issue_left = s_len;
      exp_addr = {s_src[31:2], 2'b00};
      resp_idx = 0;
      if (s_len == 0) done_cyc = cyc + 1;
      else            in_xfer  = 1;
    end
    if (exp_done) in_xfer = 0;
  endtask

  task automatic apply_reset_mid();
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("rst_mid");
    clear_model();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic run_xfer(input logic [31:0] src, input int len, input int gp, input int rp,
                          input int dp, input int hold, input int eidx, input bit mid_start);
    gnt_pct = gp; rv_pct = rp; rdy_pct = dp; hold_rdy = hold; err_idx = eidx;
    step(1, src, len);
    for (int k = 0; k < 400 + 8 * len; k++) begin
      if (!in_xfer && cyc >= done_cyc) break;
      step(mid_start && k == 2, 32'h5555_0000, 7);
    end
    chk("xfer_complete", {31'b0, !in_xfer && popped == total}, 1);
    if (in_xfer) apply_reset_mid();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; stray_rv = 0; resp_idx = 0;
    clear_model();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100; hold_rdy = 0; err_idx = -1;
    start_i = 0; src_addr_i = '0; len_i = '0; ready = 0; obi_rsp = '0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1 check_reset_outputs("rst_init");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // Basic four-word read, everything always ready.
    run_xfer(32'h1000_0000, 4, 100, 100, 100, 0, -1, 0);
    // Stream back-pressure: credit limit stops issue until ready returns.
    run_xfer(32'h1000_0100, 8, 100, 100, 100, 20, -1, 0);
    // Zero-length transfer.
    run_xfer(32'h3000_0000, 0, 100, 100, 100, 0, -1, 0);
    // Address wrap at the top of the address space.
    run_xfer(32'hFFFF_FFF8, 3, 100, 100, 100, 0, -1, 0);
    // Error on the second response; the following start clears it.
    run_xfer(32'h4000_0000, 3, 100, 100, 100, 0, 1, 0);
    run_xfer(32'h4000_1000, 2, 100, 100, 100, 0, -1, 0);
    // Start pulse while busy must be ignored.
    run_xfer(32'h6000_0002, 6, 70, 70, 70, 0, -1, 1);

    for (int i = 0; i < 12; i++) begin
      int len, eidx;
      len  = $urandom_range(1, 20);
      eidx = ($urandom_range(1) == 1) ? $urandom_range(0, len - 1) : -1;
      run_xfer($urandom, len, $urandom_range(30, 100), $urandom_range(30, 100),
               $urandom_range(30, 100), $urandom_range(0, 6), eidx, 1'($urandom_range(1)));
    end

    // Reset while draining, then a late response for an abandoned request.
    gnt_pct = 100; rv_pct = 0; rdy_pct = 100; hold_rdy = 0; err_idx = -1;
    step(1, 32'h2000_0000, 2);
    repeat (4) step(0, 32'h0, 0);
    chk("drain_outstanding_model", pq.size(), 2);
    chk("drain_busy", busy, 1);
    apply_reset_mid();
    stray_rv = 1;
    repeat (4) step(0, 32'h0, 0);
    run_xfer(32'h7000_0000, 5, 80, 80, 80, 0, -1, 0);

`ifdef USER_DMA_READER_CHECKSUM_EN
    forced.push_back(32'hA5A5_0000);
    forced.push_back(32'h0000_5A5A);
    run_xfer(32'h5000_0000, 2, 100, 100, 100, 0, -1, 0);
    repeat (2) step(0, 32'h0, 0);
    chk("checksum_held", checksum, 32'hA5A5_5A5A);
`endif

    repeat (2) step(0, 32'h0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/user_dma_reader.md
USER_DMA_READER -- requirements
Module: user_dma_reader

Interface
REQ-001 The module SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of OBI reads granted but not yet answered (legal range 1..4).
REQ-002 The module SHALL have parameter LenWidth, default 16, meaning the width of the transfer length in words.
REQ-003 The module SHALL have port clk_i, input, 1, the single clock.
REQ-004 The module SHALL have port rst_ni, input, 1, the asynchronous active-low reset.
REQ-005 The module SHALL have port start_i, input, 1, a one-cycle start pulse, sampled only in IDLE.
REQ-006 The module SHALL have port src_addr_i, input, 32, the first word address, sampled with start_i; bits [1:0] are ignored and forced to 0.
REQ-007 The module SHALL have port len_i, input, LenWidth, the number of 32-bit words to read, sampled with start_i.
REQ-008 The module SHALL have port obi_req_o, output, croc_pkg::mgr_obi_req_t, the OBI manager request into the user-domain manager port.
REQ-009 The module SHALL have port obi_rsp_i, input, croc_pkg::mgr_obi_rsp_t, the OBI response.
REQ-010 The module SHALL have ports data_o (32 bits, output), valid_o (1 bit, output) and ready_i (1 bit, input), forming the read-data stream.
REQ-011 The module SHALL have ports busy_o (1 bit, output), done_o (1 bit, output, one-cycle pulse) and err_o (1 bit, output, sticky per transfer).

Function
REQ-012 The state machine SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-013 IDLE with start_i=1 and len_i>0 SHALL move to ISSUE; with len_i=0 it SHALL move directly to DONE.
REQ-014 ISSUE SHALL assert obi_req_o.req only while words remain to issue AND outstanding+FIFO occupancy < MaxOutstanding (credit rule: a response never finds the buffer full).
REQ-015 Requests SHALL be a.we=0, a.be=4'hF, a.wdata=0, a.aid=0, with a.addr constant while req is high and not yet granted (OBI stability rule).
REQ-016 On req&gnt the address SHALL increment by 4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0 is legal), and the remaining-issue count SHALL decrement.
REQ-017 After the last grant the FSM SHALL enter DRAIN; when no responses are outstanding and the FIFO is empty it SHALL enter DONE.
REQ-018 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-019 Every rvalid SHALL push r.rdata into a MaxOutstanding-deep FIFO; valid_o = FIFO not empty, data_o = FIFO head, pop on valid_o&ready_i.
REQ-020 A response arriving in the same cycle as a pop SHALL push and pop without loss; a grant and an rvalid in the same cycle SHALL leave the outstanding count unchanged.
REQ-021 Latency SHALL be: grant in cycle n, rvalid in cycle m>n, then valid_o=1 in cycle m+1.
REQ-022 An rvalid with r.err=1 SHALL set err_o and still deliver its data word; err_o SHALL clear only on the next accepted start.
REQ-023 busy_o SHALL equal 1 in ISSUE and DRAIN; start_i while busy SHALL be ignored.
REQ-024 Counters SHALL be LenWidth bits; len_i = 2^LenWidth-1 SHALL be supported without overflow.

Reset
REQ-025 On rst_ni=0, asynchronously: state=IDLE, obi_req_o.req=0, a.addr=0, valid_o=0, data_o=0, busy_o=0, done_o=0, err_o=0, FIFO empty, all counters 0.
REQ-026 Reset mid-transfer SHALL abandon the transfer; responses to already-granted requests arriving after reset release SHALL be discarded (outstanding count is 0, so they are not pushed).

Configuration
REQ-027 With USER_DMA_READER_CHECKSUM_EN defined, the module SHALL add output checksum_o (32 bits): cleared on accepted start, updated as checksum_o ^= data_o on each stream pop, and held after DONE.
REQ-028 Without USER_DMA_READER_CHECKSUM_EN, the port and its logic SHALL be absent.

Structure
REQ-029 The FSM state enum (user_dma_reader_state_e) and the manager index constant UserDmaReader=0 SHALL live in user_pkg, with NumUserDomainManagers set to 1.
REQ-030 The response buffer SHALL be one sub-module, user_dma_fifo, parameterised by depth and data width.

Verification
REQ-031 start, src=32'h1000_0000, len=4, gnt/rvalid always 1, ready=1: addresses 0x..00, 04, 08, 0C issued; 4 words streamed in order; done_o pulses once.
REQ-032 len=8, ready_i held 0: after 2 grants req drops and stays 0; releasing ready_i resumes issue; all 8 words delivered in order, none lost.
REQ-033 len=0: done_o pulses in the cycle after start; no req asserted; busy_o stays 0.
REQ-034 src=32'hFFFF_FFF8, len=3: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 Second response has r.err=1: err_o=1 from the cycle after, 3 words still streamed, err_o cleared by the next start.
REQ-036 rst_ni pulsed low mid-DRAIN: all outputs at reset values; a late rvalid produces no valid_o; with CHECKSUM_EN, len=2 with words 0xA5A5_0000 and 0x0000_5A5A yields checksum_o=0xA5A5_5A5A.
